// File: rtl/rr_mux_nway.sv
// rr_mux_nway: registered N-way valid/ready mux with round-robin arbitration
// and packet lock that holds a grant until the last beat is accepted.
module rr_mux_nway #(
    parameter int WIDTH = 16,
    parameter int NUM_CH = 4,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic [SEL_W-1:0] ptr, lock_ch, gnt;
    logic             locked, gnt_vld, load_en, xfer;
    assign load_en = !out_valid || out_ready;
    // Descending scan so the nearest channel after ptr wins the final assignment.
    always_comb begin
        gnt = lock_ch;
        gnt_vld = locked && in_valid[lock_ch];
        if (!locked)
            for (int k = NUM_CH; k >= 1; k--)
                if (in_valid[(int'(ptr) + k) % NUM_CH]) begin
                    gnt = SEL_W'((int'(ptr) + k) % NUM_CH);
                    gnt_vld = 1'b1;
                end
    end
    assign xfer = load_en && gnt_vld;
    assign in_ready = {NUM_CH{xfer}} & (NUM_CH'(1) << gnt);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            ptr       <= SEL_W'(NUM_CH - 1);
            locked    <= 1'b0;
            lock_ch   <= '0;
        end else if (xfer) begin
            out_data  <= in_data[gnt*WIDTH +: WIDTH];
            out_ch    <= gnt;
            out_last  <= in_last[gnt];
            out_valid <= 1'b1;
            locked    <= !in_last[gnt];
            if (in_last[gnt]) ptr <= gnt;
            else lock_ch <= gnt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_mux_nway.sv
// tb_rr_mux_nway: scoreboard bench; a queue-level reference model predicts
// grants and output beats, a separate monitor checks beats as they drain.
module tb_rr_mux_nway;
    logic        clk = 0, rst_n = 0;
    logic [63:0] in_data = '0;
    logic [3:0]  in_valid = '0, in_last = '0, in_ready;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_last, out_valid, out_ready = 0;
    logic [23:0] in_data3 = '0;
    logic [2:0]  in_valid3 = '0, in_last3 = '0, in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_last3, out_valid3, out_ready3 = 0;

    rr_mux_nway dut (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_ch(out_ch),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready));
    rr_mux_nway #(.WIDTH(8), .NUM_CH(3)) dut3 (.clk(clk), .rst_n(rst_n), .in_data(in_data3),
        .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3),
        .out_ch(out_ch3), .out_last(out_last3), .out_valid(out_valid3), .out_ready(out_ready3));

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;
    logic [18:0] exp_q[$];
    int owner = -1, last_served = 3;
    bit mv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: owner holds the channel mid-packet; otherwise scan cyclically after the last served channel.
    task automatic step(output int acc);
        int g;
        bit le;
        #1;
        le = !mv || out_ready;
        g = -1;
        if (owner >= 0) g = in_valid[owner] ? owner : -1;
        else for (int k = 1; k <= 4; k++) if (g < 0 && in_valid[(last_served + k) % 4]) g = (last_served + k) % 4;
        acc = (le && g >= 0) ? g : -1;
        chk("in_ready", {60'd0, in_ready}, (acc >= 0) ? 64'(1 << acc) : 64'd0);
        if (acc >= 0) begin
            exp_q.push_back({in_last[acc], 2'(acc), in_data[acc*16 +: 16]});
            if (in_last[acc]) begin owner = -1; last_served = acc; end
            else owner = acc;
            mv = 1;
        end else if (out_ready) mv = 0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tot++;
                $display("FAIL out_beat: unexpected beat data=0x%0h ch=%0d expected none", out_data, out_ch);
            end else chk("out_beat", {45'd0, out_last, out_ch, out_data}, {45'd0, exp_q.pop_front()});
        end
    end

    bit          pres[4], mid[4], gl[4];
    logic [15:0] gd[4];

    task automatic gen_drive(input bit draining);
        for (int i = 0; i < 4; i++) begin
            if (!pres[i] && (mid[i] || (!draining && $urandom_range(9) < 6))) begin
                pres[i] = 1;
                gd[i] = 16'($urandom);
                gl[i] = draining || ($urandom_range(2) != 0);
            end
            in_valid[i] = pres[i];
            in_last[i] = gl[i];
            in_data[i*16 +: 16] = pres[i] ? gd[i] : 16'hxxxx;
        end
    endtask

    task automatic gen_accept(input int acc);
        if (acc >= 0) begin pres[acc] = 0; mid[acc] = !gl[acc]; end
    endtask

    initial begin
        int acc;
        logic [3:0] rdy_seq[5];
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 0);
        chk("rst_out_data", {48'd0, out_data}, 0);
        chk("rst_out_ch", {62'd0, out_ch}, 0);
        chk("rst_out_last", {63'd0, out_last}, 0);
        rst_n = 1;
        // All channels valid with single-beat packets: pure round robin from channel 0.
        in_valid = 4'b1111; in_last = 4'b1111; out_ready = 1;
        in_data = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        rdy_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            #1 chk("rr_grant", {60'd0, in_ready}, {60'd0, rdy_seq[i]});
            step(acc);
        end
        in_valid = 4'b0100; in_last = 4'b0100; in_data = {16'h0, 16'hBEEF, 32'h0};
        #1 chk("single_ready", {60'd0, in_ready}, 64'b0100);
        step(acc);
        in_valid = 0;
        chk("single_data", {48'd0, out_data}, 16'hBEEF);
        chk("single_ch", {62'd0, out_ch}, 2);
        chk("single_vl", {62'd0, out_valid, out_last}, 2'b11);
        // Channel 1 locks for a 3-beat packet while 0 and 3 compete.
        rdy_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 0) ? 4'b0010 : (i < 3) ? 4'b1011 : (i == 3) ? 4'b1001 : 4'b0001;
            in_last = (i == 2) ? 4'b1011 : 4'b1001;
            in_data = {16'h3003, 16'h0, 16'(16'h0011 * (i + 1)), 16'h0000};
            #1 chk("lock_grant", {60'd0, in_ready}, {60'd0, rdy_seq[i]});
            step(acc);
        end
        in_valid = 4'b0001; in_last = 4'b0001; in_data = {48'h0, 16'h1234};
        step(acc);
        in_valid = 4'b0010; in_last = 4'b0010; in_data = {32'h0, 16'h5678, 16'h0}; out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("stall_ready", {60'd0, in_ready}, 0);
            chk("stall_data", {48'd0, out_data}, 16'h1234);
            step(acc);
        end
        out_ready = 1;
        #1 chk("b2b_ready", {60'd0, in_ready}, 64'b0010);
        step(acc);
        in_valid = 0;
        chk("b2b_data", {48'd0, out_data}, 16'h5678);
        // Reset while locked on channel 2.
        in_valid = 4'b0100; in_last = 4'b0000; in_data = {16'h0, 16'hABCD, 32'h0};
        step(acc);
        in_valid = 0;
        #3 rst_n = 0;
        #1 chk("arst_valid", {63'd0, out_valid}, 0);
        chk("arst_data", {48'd0, out_data}, 0);
        chk("arst_ch_last", {61'd0, out_ch, out_last}, 0);
        owner = -1; last_served = 3; mv = 0; exp_q.delete();
        @(negedge clk);
        rst_n = 1;
        in_valid = 4'b0101; in_last = 4'b0101; in_data = {16'h0, 16'hC2C2, 16'h0, 16'hC0C0};
        #1 chk("post_rst_grant", {60'd0, in_ready}, 64'b0001);
        step(acc);
        #1 chk("post_rst_next", {60'd0, in_ready}, 64'b0100);
        step(acc);
        in_valid = 0;
        // Randomized traffic with random backpressure, then drain.
        for (int c = 0; c < 600; c++) begin
            gen_drive(0);
            out_ready = ($urandom_range(9) < 7);
            step(acc);
            gen_accept(acc);
        end
        out_ready = 1;
        for (int c = 0; c < 300; c++) begin
            if (!(pres[0] || pres[1] || pres[2] || pres[3]) && exp_q.size() == 0 && !mv) break;
            gen_drive(1);
            step(acc);
            gen_accept(acc);
        end
        in_valid = 0;
        @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 0);
        // Three-channel instance: wrap-around modulo 3.
        in_valid3 = 3'b111; in_last3 = 3'b111; in_data3 = 24'h332211; out_ready3 = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk("n3_grant", {61'd0, in_ready3}, 64'(1 << (i % 3)));
            @(negedge clk);
            chk("n3_out_ch", {62'd0, out_ch3}, 64'(i % 3));
            chk("n3_out_data", {56'd0, out_data3}, 64'(8'h11 * (i % 3 + 1)));
        end
        in_valid3 = 0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/rr_mux_nway.md
Name: rr_mux_nway

Overview:
- Parametrised, registered N-way multiplexer for WIDTH-bit data.
- Round-robin arbitration across NUM_CH valid/ready input channels.
- Packet lock: a grant is held until the beat marked last is accepted.
- Sits between multiple producers (ALU result, memory read, I/O) and a single shared datapath consumer; this is the sequential generation of the 2-way 16-bit mux.

Parameters:
- WIDTH, 16, data width per channel (1..64).
- NUM_CH, 4, number of input channels (2..8).
- SEL_W, $clog2(NUM_CH), width of channel index; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_last  in  NUM_CH  per-channel last-beat-of-packet flag.
- in_ready  out  NUM_CH  per-channel ready (combinational).
- out_data  out  WIDTH  registered selected data.
- out_ch  out  SEL_W  registered index of source channel.
- out_last  out  1  registered last flag.
- out_valid  out  1  output holds a beat.
- out_ready  in  1  consumer accepts the beat.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_ch=0, out_last=0.
  - Round-robin pointer ptr=NUM_CH-1, so channel 0 has first priority.
  - locked=0, lock_ch=0.
- Load enable: load_en = !out_valid || out_ready. The single output register accepts a new beat while being drained, giving full throughput.
- Grant, combinational:
  - If locked: gnt = lock_ch, regardless of other valids. If lock_ch is not valid, nothing is granted (bubble).
  - Else: gnt = first i with in_valid[i]=1, searching ptr+1, ptr+2, … modulo NUM_CH.
  - gnt_vld = a valid channel was granted.
- in_ready[i] = load_en && gnt_vld && (gnt==i). At most one bit is set. in_ready must not depend on in_valid of other channels when locked.
- Transfer on channel i = in_valid[i] && in_ready[i]. On that rising edge:
  - out_data <= channel i data; out_ch <= i; out_last <= in_last[i]; out_valid <= 1.
  - If in_last[i]=1: locked <= 0 and ptr <= i.
  - If in_last[i]=0: locked <= 1 and lock_ch <= i; ptr is unchanged.
- No transfer and out_ready=1: out_valid <= 0. Data, channel and last fields keep their values.
- Output stall (out_valid=1, out_ready=0): out_data, out_ch and out_last are held stable; all in_ready=0.
- Latency: one clock from input transfer to out_valid.
- Throughput: one beat per clock when out_ready is held high.
- Single-beat packets: every beat has last=1, giving pure round-robin per beat.
- Wrap-around: with ptr=NUM_CH-1, the search order is 0,1,…,NUM_CH-1.
- Simultaneous valids: exactly one is granted; the others see in_ready=0 and must hold their data.
- Reset mid-packet clears locked; the next grant is channel 0 if it is valid.
- A channel dropping in_valid mid-packet is illegal upstream. The block stays locked and stalls; it does not error.
- No X may propagate from in_data of non-granted channels to the outputs.

Test Plan:
- Reset → out_valid=0, out_data=0x0000; with in_valid=4'b1111, in_last=4'b1111, out_ready=1, grants are 0,1,2,3,0 on five consecutive cycles; out_ch follows one cycle later.
- in_valid=4'b0100 only, data 0xBEEF, last=1 → in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=0xBEEF, out_ch=2, out_last=1.
- Channel 1 sends 3-beat packet 0x0011, 0x0022, 0x0033 (last on third) while channels 0 and 3 are valid → three consecutive outputs from ch1; next grant ch3, then ch0.
- out_ready=0 for 4 cycles with out_valid=1, data 0x1234 → out_data stays 0x1234, in_ready=0 throughout; releasing out_ready gives a back-to-back new beat on the same edge the old one drains.
- rst_n asserted low mid-packet (locked on ch2) → outputs clear immediately, asynchronously; after release with in_valid=4'b0101, ch0 is granted first.
- NUM_CH=3, WIDTH=8 instance, all valid → grant order 0,1,2,0 with correct modulo wrap; out_ch width is 2.
